// File: rtl/axi_memory_slave_nrd_if.sv
// Bus bundle for axi_memory_slave_nrd: one AXI-style write channel (AW/W/B)
// and NUM_RD read channels (AR/R) packed lane-wise.
// Read lane i sits at [i*ADDR_WIDTH +: ADDR_WIDTH] for araddr,
// [i*8 +: 8] for arlen, [i*DATA_WIDTH +: DATA_WIDTH] for rdata and
// [i*2 +: 2] for rresp. It uses bit i for the single-bit signals.
// Modports: slave (the memory) and master (the client or testbench side).
interface axi_memory_slave_nrd_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_RD     = 2
);
   logic [ADDR_WIDTH-1:0]        awaddr;
   logic [7:0]                   awlen;
   logic                         awvalid;
   logic                         awready;
   logic [DATA_WIDTH-1:0]        wdata;
   logic                         wlast;
   logic                         wvalid;
   logic                         wready;
   logic [1:0]                   bresp;
   logic                         bvalid;
   logic                         bready;
   logic [NUM_RD*ADDR_WIDTH-1:0] araddr;
   logic [NUM_RD*8-1:0]          arlen;
   logic [NUM_RD-1:0]            arvalid;
   logic [NUM_RD-1:0]            arready;
   logic [NUM_RD*DATA_WIDTH-1:0] rdata;
   logic [NUM_RD*2-1:0]          rresp;
   logic [NUM_RD-1:0]            rlast;
   logic [NUM_RD-1:0]            rvalid;
   logic [NUM_RD-1:0]            rready;

   modport slave (
      input  awaddr, awlen, awvalid, wdata, wlast, wvalid, bready,
             araddr, arlen, arvalid, rready,
      output awready, wready, bresp, bvalid,
             arready, rdata, rresp, rlast, rvalid
   );

   modport master (
      output awaddr, awlen, awvalid, wdata, wlast, wvalid, bready,
             araddr, arlen, arvalid, rready,
      input  awready, wready, bresp, bvalid,
             arready, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/axi_memory_slave_nrd.sv
// Word-addressed frame-buffer memory with one write channel and NUM_RD read
// channels. The read channels share one registered read port through a
// round-robin arbiter. Accesses at or above MEM_SIZE are dropped on writes,
// read back as zero, and are flagged with SLVERR (2'b10).
// Ports: clk, rst_n (synchronous, active low), bus (slave modport).
// Memory contents come from INIT_OPTION at time zero and survive reset.
//
// state   | meaning
// W_IDLE  | awready high, waiting for a write burst address
// W_DATA  | wready high, one beat written per wvalid, awlen+1 beats total
// W_RESP  | bvalid high with the burst's error status, waiting for bready
// R_IDLE  | arready[i] high, waiting for a read burst on channel i
// R_BURST | channel i issues reads until its last beat is handshaken
module axi_memory_slave_nrd #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_SIZE    = 32,
   parameter int NUM_RD      = 2,
   parameter int INIT_OPTION = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   axi_memory_slave_nrd_if.slave  bus
);
   localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
   localparam int PTR_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
   localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_SIZE);

   typedef logic [MEM_SIZE-1:0][DATA_WIDTH-1:0] mem_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_BURST} r_state_t;

   function automatic mem_t init_mem();
      mem_t m;
      for (int j = 0; j < MEM_SIZE; j++) m[j] = (INIT_OPTION == 1) ? DATA_WIDTH'(j) : '0;
      return m;
   endfunction

   // The initial contents are a power-up value, so reset does not touch them.
   mem_t mem = init_mem();

   w_state_t              w_state, w_next;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [7:0]            w_cnt;
   logic                  w_err;
   logic                  w_beat, w_inrange;

   r_state_t [NUM_RD-1:0]                 rd_state, rd_next;
   logic     [NUM_RD-1:0][ADDR_WIDTH-1:0] rd_addr;
   logic     [NUM_RD-1:0][8:0]            rd_rem;
   logic     [NUM_RD-1:0]                 rd_req, gnt_oh, rvalid_q, rlast_q;
   logic     [NUM_RD-1:0][1:0]            rresp_q;
   logic     [NUM_RD-1:0][DATA_WIDTH-1:0] rdata_q;
   logic     [PTR_W-1:0]                  rr_ptr, gnt_idx;
   logic                                  gnt_any;

   assign w_beat    = (w_state == W_DATA) && bus.wvalid;
   assign w_inrange = w_addr < MEM_LIMIT;

   always_ff @(posedge clk) begin
      if (!rst_n) w_state <= W_IDLE;
      else        w_state <= w_next;
   end

   always_comb begin
      w_next      = w_state;
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      bus.bvalid  = 1'b0;
      bus.bresp   = 2'b00;
      case (w_state)
         W_IDLE: begin
            bus.awready = 1'b1;
            if (bus.awvalid) w_next = W_DATA;
         end
         W_DATA: begin
            bus.wready = 1'b1;
            if (bus.wvalid && (w_cnt == 8'd0)) w_next = W_RESP;
         end
         W_RESP: begin
            bus.bvalid = 1'b1;
            bus.bresp  = w_err ? 2'b10 : 2'b00;
            if (bus.bready) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         w_addr <= '0;
         w_cnt  <= '0;
         w_err  <= 1'b0;
      end else begin
         if ((w_state == W_IDLE) && bus.awvalid) begin
            w_addr <= bus.awaddr;
            w_cnt  <= bus.awlen;
            w_err  <= 1'b0;
         end
         if (w_beat) begin
            // The beat count ends the burst, so wlast only affects the status.
            if (!w_inrange || ((w_cnt == 8'd0) != bus.wlast)) w_err <= 1'b1;
            w_addr <= w_addr + 1'b1;
            w_cnt  <= w_cnt - 1'b1;
         end
      end
   end

   // Gating on rst_n keeps a beat that coincides with reset out of the array.
   always_ff @(posedge clk) begin
      if (rst_n && w_beat && w_inrange) mem[w_addr[IDX_W-1:0]] <= bus.wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_RD; i++) rd_state[i] <= R_IDLE;
      end else begin
         rd_state <= rd_next;
      end
   end

   always_comb begin
      rd_next     = rd_state;
      rd_req      = '0;
      bus.arready = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         case (rd_state[i])
            R_IDLE: begin
               bus.arready[i] = 1'b1;
               if (bus.arvalid[i]) rd_next[i] = R_BURST;
            end
            R_BURST: begin
               // Request only when the output register is free, or frees this cycle.
               rd_req[i] = (rd_rem[i] != 9'd0) && (!rvalid_q[i] || bus.rready[i]);
               if (rvalid_q[i] && bus.rready[i] && rlast_q[i]) rd_next[i] = R_IDLE;
            end
            default: rd_next[i] = R_IDLE;
         endcase
      end
   end

   // The arbiter grants the first requester at or after rr_ptr, wrapping around.
   always_comb begin
      int idx;
      gnt_oh  = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      for (int k = 0; k < NUM_RD; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_RD) idx = idx - NUM_RD;
         if (!gnt_any && rd_req[idx]) begin
            gnt_any     = 1'b1;
            gnt_oh[idx] = 1'b1;
            gnt_idx     = PTR_W'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_addr  <= '0;
         rd_rem   <= '0;
         rvalid_q <= '0;
         rlast_q  <= '0;
         rresp_q  <= '0;
         rdata_q  <= '0;
         rr_ptr   <= '0;
      end else begin
         for (int i = 0; i < NUM_RD; i++) begin
            if ((rd_state[i] == R_IDLE) && bus.arvalid[i]) begin
               rd_addr[i] <= bus.araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
               rd_rem[i]  <= {1'b0, bus.arlen[i*8 +: 8]} + 9'd1;
            end
            if (gnt_oh[i]) begin
               rvalid_q[i] <= 1'b1;
               rlast_q[i]  <= (rd_rem[i] == 9'd1);
               if (rd_addr[i] < MEM_LIMIT) begin
                  rdata_q[i] <= mem[rd_addr[i][IDX_W-1:0]];
                  rresp_q[i] <= 2'b00;
               end else begin
                  rdata_q[i] <= '0;
                  rresp_q[i] <= 2'b10;
               end
               rd_addr[i] <= rd_addr[i] + 1'b1;
               rd_rem[i]  <= rd_rem[i] - 9'd1;
            end else if (rvalid_q[i] && bus.rready[i]) begin
               rvalid_q[i] <= 1'b0;
            end
         end
         if (gnt_any) rr_ptr <= (gnt_idx == PTR_W'(NUM_RD - 1)) ? '0 : gnt_idx + PTR_W'(1);
      end
   end

   assign bus.rvalid = rvalid_q;
   assign bus.rlast  = rlast_q;
   assign bus.rresp  = rresp_q;
   assign bus.rdata  = rdata_q;
endmodule

// File: tb/tb_axi_memory_slave_nrd.sv
module tb_axi_memory_slave_nrd;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MS = 32;
   localparam int NR = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   nerr = 0;
   int   nchk = 0;

   always #5 clk = ~clk;

   axi_memory_slave_nrd_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR)) bus ();

   axi_memory_slave_nrd #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS), .NUM_RD(NR), .INIT_OPTION(1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Expected read-side state after each edge of a read sequence.
   logic [1:0]  t_rv [1:16];
   logic [31:0] t_d0 [1:16];
   logic [31:0] t_d1 [1:16];
   logic [1:0]  t_rl [1:16];
   logic [3:0]  t_rs [1:16];
   logic [1:0]  t_rr [1:16];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic row(input int n, input logic [1:0] rv, input logic [31:0] d0,
                      input logic [31:0] d1, input logic [1:0] rl, input logic [3:0] rs,
                      input logic [1:0] rr);
      t_rv[n] = rv; t_d0[n] = d0; t_d1[n] = d1; t_rl[n] = rl; t_rs[n] = rs; t_rr[n] = rr;
   endtask

   task automatic run_table(input string tag, input int n);
      logic [3:0] m;
      for (int k = 1; k <= n; k++) begin
         bus.rready = t_rr[k];
         @(posedge clk);
         @(negedge clk);
         m = {{2{bus.rvalid[1]}}, {2{bus.rvalid[0]}}};
         chk($sformatf("%s rvalid step%0d", tag, k), 64'(bus.rvalid), 64'(t_rv[k]));
         if (t_rv[k][0]) chk($sformatf("%s rdata0 step%0d", tag, k), 64'(bus.rdata[31:0]), 64'(t_d0[k]));
         if (t_rv[k][1]) chk($sformatf("%s rdata1 step%0d", tag, k), 64'(bus.rdata[63:32]), 64'(t_d1[k]));
         chk($sformatf("%s rlast step%0d", tag, k), 64'(bus.rlast & bus.rvalid), 64'(t_rl[k]));
         chk($sformatf("%s rresp step%0d", tag, k), 64'(bus.rresp & m), 64'(t_rs[k]));
      end
      bus.rready = 2'b11;
   endtask

   task automatic issue_ar(input logic [1:0] v, input logic [31:0] a0, input logic [7:0] l0,
                           input logic [31:0] a1, input logic [7:0] l1);
      bus.araddr  = {a1, a0};
      bus.arlen   = {l1, l0};
      bus.arvalid = v;
      chk("arready idle", 64'(bus.arready), 64'(2'b11));
      @(posedge clk);
      @(negedge clk);
      bus.arvalid = 2'b00;
   endtask

   task automatic write_burst(input string tag, input logic [31:0] addr, input logic [7:0] len,
                              input logic [3:0][31:0] d, input logic [3:0] lastm,
                              input logic [1:0] exp_resp);
      bus.awaddr  = addr;
      bus.awlen   = len;
      bus.awvalid = 1'b1;
      chk({tag, " awready"}, 64'(bus.awready), 64'(1));
      @(posedge clk);
      @(negedge clk);
      bus.awvalid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         bus.wdata  = d[b];
         bus.wlast  = lastm[b];
         bus.wvalid = 1'b1;
         chk($sformatf("%s wready beat%0d", tag, b), 64'(bus.wready), 64'(1));
         @(posedge clk);
         @(negedge clk);
      end
      bus.wvalid = 1'b0;
      bus.wlast  = 1'b0;
      chk({tag, " wready done"}, 64'(bus.wready), 64'(0));
      chk({tag, " bvalid"}, 64'(bus.bvalid), 64'(1));
      chk({tag, " bresp"}, 64'(bus.bresp), 64'(exp_resp));
      bus.bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.bready = 1'b0;
      chk({tag, " bvalid cleared"}, 64'(bus.bvalid), 64'(0));
      chk({tag, " awready again"}, 64'(bus.awready), 64'(1));
   endtask

   task automatic check_reset(input string tag);
      chk({tag, " awready"}, 64'(bus.awready), 64'(1));
      chk({tag, " wready"},  64'(bus.wready),  64'(0));
      chk({tag, " bvalid"},  64'(bus.bvalid),  64'(0));
      chk({tag, " bresp"},   64'(bus.bresp),   64'(0));
      chk({tag, " arready"}, 64'(bus.arready), 64'(2'b11));
      chk({tag, " rvalid"},  64'(bus.rvalid),  64'(0));
      chk({tag, " rlast"},   64'(bus.rlast),   64'(0));
      chk({tag, " rresp"},   64'(bus.rresp),   64'(0));
      chk({tag, " rdata"},   64'(bus.rdata),   64'(0));
   endtask

   initial begin
      bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
      bus.araddr = '0; bus.arlen = '0; bus.arvalid = '0; bus.rready = 2'b11;

      repeat (2) @(negedge clk);
      check_reset("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Two channels contend for addresses 0..3 of the identity-initialised array.
      row(1, 2'b01, 32'd0, 32'd0, 2'b00, 4'h0, 2'b11);
      row(2, 2'b10, 32'd0, 32'd0, 2'b00, 4'h0, 2'b11);
      row(3, 2'b01, 32'd1, 32'd0, 2'b00, 4'h0, 2'b11);
      row(4, 2'b10, 32'd0, 32'd1, 2'b00, 4'h0, 2'b11);
      row(5, 2'b01, 32'd2, 32'd0, 2'b00, 4'h0, 2'b11);
      row(6, 2'b10, 32'd0, 32'd2, 2'b00, 4'h0, 2'b11);
      row(7, 2'b01, 32'd3, 32'd0, 2'b01, 4'h0, 2'b11);
      row(8, 2'b10, 32'd0, 32'd3, 2'b10, 4'h0, 2'b11);
      row(9, 2'b00, 32'd0, 32'd0, 2'b00, 4'h0, 2'b11);
      issue_ar(2'b11, 32'd0, 8'd3, 32'd0, 8'd3);
      run_table("contend", 9);
      chk("contend idle arready", 64'(bus.arready), 64'(2'b11));

      // Channel 1 stalls for five cycles; channel 0 streams meanwhile.
      row(1,  2'b01, 32'd16, 32'd0,  2'b00, 4'h0, 2'b11);
      row(2,  2'b10, 32'd0,  32'd8,  2'b00, 4'h0, 2'b11);
      row(3,  2'b01, 32'd17, 32'd0,  2'b00, 4'h0, 2'b11);
      row(4,  2'b10, 32'd0,  32'd9,  2'b00, 4'h0, 2'b11);
      row(5,  2'b11, 32'd18, 32'd9,  2'b00, 4'h0, 2'b01);
      row(6,  2'b11, 32'd19, 32'd9,  2'b00, 4'h0, 2'b01);
      row(7,  2'b11, 32'd20, 32'd9,  2'b00, 4'h0, 2'b01);
      row(8,  2'b11, 32'd21, 32'd9,  2'b00, 4'h0, 2'b01);
      row(9,  2'b11, 32'd22, 32'd9,  2'b00, 4'h0, 2'b01);
      row(10, 2'b10, 32'd0,  32'd10, 2'b00, 4'h0, 2'b11);
      row(11, 2'b01, 32'd23, 32'd0,  2'b01, 4'h0, 2'b11);
      row(12, 2'b10, 32'd0,  32'd11, 2'b10, 4'h0, 2'b11);
      row(13, 2'b00, 32'd0,  32'd0,  2'b00, 4'h0, 2'b11);
      issue_ar(2'b11, 32'd16, 8'd7, 32'd8, 8'd3);
      run_table("stall", 13);

      // Write four words at 0, then read them back on channel 0.
      write_burst("wr0", 32'd0, 8'd3,
                  {32'h87654321, 32'h12345678, 32'h5A5A5A5A, 32'hA5A5A5A5}, 4'b1000, 2'b00);
      row(1, 2'b01, 32'hA5A5A5A5, 32'd0, 2'b00, 4'h0, 2'b11);
      row(2, 2'b01, 32'h5A5A5A5A, 32'd0, 2'b00, 4'h0, 2'b11);
      row(3, 2'b01, 32'h12345678, 32'd0, 2'b00, 4'h0, 2'b11);
      row(4, 2'b01, 32'h87654321, 32'd0, 2'b01, 4'h0, 2'b11);
      row(5, 2'b00, 32'd0,        32'd0, 2'b00, 4'h0, 2'b11);
      issue_ar(2'b01, 32'd0, 8'd3, 32'd0, 8'd0);
      run_table("rdback", 5);

      // Burst runs past the end of the array.
      write_burst("wroor", 32'd30, 8'd3,
                  {32'hC0DE0021, 32'hC0DE0020, 32'hC0DE001F, 32'hC0DE001E}, 4'b1000, 2'b10);
      row(1, 2'b10, 32'd0,        32'hC0DE001E, 2'b10, 4'h0, 2'b11);
      row(2, 2'b01, 32'hC0DE001F, 32'd0,        2'b00, 4'h0, 2'b11);
      row(3, 2'b01, 32'd0,        32'd0,        2'b01, 4'h2, 2'b11);
      row(4, 2'b00, 32'd0,        32'd0,        2'b00, 4'h0, 2'b11);
      issue_ar(2'b11, 32'd31, 8'd1, 32'd30, 8'd0);
      run_table("rdoor", 4);
      row(1, 2'b01, 32'hA5A5A5A5, 32'd0, 2'b00, 4'h0, 2'b11);
      row(2, 2'b01, 32'h5A5A5A5A, 32'd0, 2'b01, 4'h0, 2'b11);
      row(3, 2'b00, 32'd0,        32'd0, 2'b00, 4'h0, 2'b11);
      issue_ar(2'b01, 32'd0, 8'd1, 32'd0, 8'd0);
      run_table("nowrap", 3);

      // wlast on the first of two beats.
      write_burst("wlast", 32'd4, 8'd1, {32'd0, 32'd0, 32'h00002222, 32'h00001111}, 4'b0001, 2'b10);
      row(1, 2'b10, 32'd0, 32'h00001111, 2'b00, 4'h0, 2'b11);
      row(2, 2'b10, 32'd0, 32'h00002222, 2'b10, 4'h0, 2'b11);
      row(3, 2'b00, 32'd0, 32'd0,        2'b00, 4'h0, 2'b11);
      issue_ar(2'b10, 32'd0, 8'd0, 32'd4, 8'd1);
      run_table("rdwlast", 3);

      // Reset during beat 2 of a 4-beat write at 8 and a read at 16.
      bus.awaddr = 32'd8; bus.awlen = 8'd3; bus.awvalid = 1'b1;
      bus.araddr = {32'd0, 32'd16}; bus.arlen = {8'd0, 8'd3}; bus.arvalid = 2'b01;
      @(posedge clk);
      @(negedge clk);
      bus.awvalid = 1'b0; bus.arvalid = 2'b00;
      bus.wdata = 32'hDEAD0008; bus.wvalid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst pre rvalid", 64'(bus.rvalid), 64'(2'b01));
      chk("midrst pre rdata0", 64'(bus.rdata[31:0]), 64'(32'd16));
      bus.wdata = 32'hDEAD0009;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset("midrst");
      rst_n = 1'b1;
      bus.wdata = 32'hDEAD000A;
      @(posedge clk);
      @(negedge clk);
      bus.wdata = 32'hDEAD000B;
      @(posedge clk);
      @(negedge clk);
      bus.wvalid = 1'b0;
      chk("midrst bvalid", 64'(bus.bvalid), 64'(0));
      chk("midrst awready", 64'(bus.awready), 64'(1));

      // Pointer is back at channel 0; words 10 and 11 keep their initial values.
      row(1, 2'b01, 32'd10, 32'd0,  2'b00, 4'h0, 2'b11);
      row(2, 2'b10, 32'd0,  32'd12, 2'b10, 4'h0, 2'b11);
      row(3, 2'b01, 32'd11, 32'd0,  2'b01, 4'h0, 2'b11);
      row(4, 2'b00, 32'd0,  32'd0,  2'b00, 4'h0, 2'b11);
      issue_ar(2'b11, 32'd10, 8'd1, 32'd12, 8'd0);
      run_table("postrst", 4);
      row(1, 2'b01, 32'hDEAD0008, 32'd0, 2'b01, 4'h0, 2'b11);
      row(2, 2'b00, 32'd0,        32'd0, 2'b00, 4'h0, 2'b11);
      issue_ar(2'b01, 32'd8, 8'd0, 32'd0, 8'd0);
      run_table("beat1kept", 2);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule

// File: doc/axi_memory_slave_nrd.md
# axi_memory_slave_nrd

AXI-style word-addressed memory slave with one write channel and NUM_RD independent read channels sharing a single 1R1W memory array. It generalises the fixed 3-channel slave: the read channel count is a parameter, reads are arbitrated round-robin onto one memory read port, and out-of-range accesses return SLVERR. It sits between the frame writer and the parallel read clients of the processing pipeline, and serves as the simulation and synthesis frame buffer.

## Interface
- ADDR_WIDTH, 32, address width; addresses are word indices.
- DATA_WIDTH, 32, word width.
- MEM_SIZE, 32, depth in words; must be a power of 2.
- NUM_RD, 2, number of read channels; legal range 1..8.
- INIT_OPTION, 0, array init: 0 sets mem[i]=0, 1 sets mem[i]=i. Applied at time 0, not on reset.
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- awaddr  in  ADDR_WIDTH  write burst start word address.
- awlen  in  8  beats minus 1.
- awvalid  in  1 / awready  out  1  write address handshake.
- wdata  in  DATA_WIDTH / wlast  in  1 / wvalid  in  1 / wready  out  1  write data.
- bresp  out  2 / bvalid  out  1 / bready  in  1  write response.
- araddr  in  NUM_RD*ADDR_WIDTH  channel i is at [i*ADDR_WIDTH +: ADDR_WIDTH].
- arlen  in  NUM_RD*8 / arvalid  in  NUM_RD / arready  out  NUM_RD  read address, one lane per channel.
- rdata  out  NUM_RD*DATA_WIDTH / rresp  out  NUM_RD*2 / rlast  out  NUM_RD / rvalid  out  NUM_RD / rready  in  NUM_RD  read data, one lane per channel.

## Operation
- **Write FSM: W_IDLE → W_DATA → W_RESP → W_IDLE.**
  - W_IDLE: awready=1. On awvalid, latch the address, set the beat counter to awlen, and clear the error flag.
  - W_DATA: wready=1. Each wvalid beat writes mem[addr] when addr<MEM_SIZE; out-of-range beats are dropped and set the error flag. The address increments by 1 with no wrap.
  - The burst ends on beat awlen+1, regardless of wlast. A wlast value that does not match the final beat sets the error flag.
  - W_RESP: bvalid=1, bresp=2'b10 if the error flag is set, otherwise 2'b00. Hold until bready.
- **Read FSM, per channel i: R_IDLE → R_BURST → R_IDLE.**
  - R_IDLE: arready[i]=1. On arvalid[i], latch the address and remaining=arlen+1.
  - R_BURST: the channel requests the memory port when remaining>0 and its output register is free (!rvalid[i] || rready[i]).
  - On grant, the output register loads in the next cycle: rdata = mem[addr] if addr<MEM_SIZE, else 0; rresp = 00 or 10 accordingly; rlast=(remaining==1). Then addr++ and remaining--.
  - The channel returns to R_IDLE on the edge where rvalid&rready&rlast all hold.
- **Arbiter:** round-robin over requesting channels. The pointer moves to the channel after the last granted one; one grant per cycle.
- **Read/write ordering:** the memory read is registered. A read granted at the same edge as a write to the same address returns the old data. A write at edge t is visible to grants at edge t+1 or later.
- **Independence:** write and read channels run concurrently with no ordering between them.

## Timing
- **Reset** (at the first edge with rst_n=0, and at any reset mid-burst, which aborts all bursts without writing further beats):
  - all FSMs go to IDLE.
  - awready=1, wready=0, bvalid=0, bresp=0.
  - arready=all 1s, rvalid=0, rlast=0, rresp=0, rdata=0.
  - the arbiter pointer is set to channel 0.
  - memory contents are kept.
- **Write timing:** with the AW handshake at edge t0, wready=1 from t0 to the last beat edge, and bvalid=1 after the last beat edge. The next AW can be accepted one cycle after the B handshake edge.
- **Read latency:** with the AR handshake at edge t0, the first grant is at t0+1 and rvalid[i] rises after t0+1.
  - A sole requester with rready held high streams one beat per cycle.
  - k contending channels each get 1 beat per k cycles.
- **Read stall:** while rvalid[i]=1 and rready[i]=0, rdata, rresp and rlast hold stable and channel i does not request.
- **Simultaneous handshakes:** simultaneous AR handshakes on several channels are all accepted. The first grant goes to the lowest index at or after the pointer.
- **Zero-length bursts:** awlen=0 / arlen=0 are single-beat bursts, and rlast is asserted on that beat.

## Test plan
- **Write then read, INIT_OPTION=0:** write awaddr=0, awlen=3 with data A5A5A5A5, 5A5A5A5A, 12345678, 87654321 → bresp=00. Then read on channel 0 → same four words, rlast on the 4th, rresp=00.
- **Two-channel contention, INIT_OPTION=1:** channels 0 and 1 both issue araddr=0, arlen=3 at the same edge, rready=1 → beats alternate ch0/ch1. Each receives 0,1,2,3, and each completes within 9 cycles of the AR edge.
- **Backpressure:** channel 1 has rready=0 for 5 cycles mid-burst → rdata held stable. Channel 0's throughput rises to 1 beat per cycle during the stall, and no beats are lost.
- **Out of range, MEM_SIZE=32:** write awaddr=30, awlen=3 → mem[30], mem[31] written, bresp=10. Read araddr=31, arlen=1 → beat 0 rresp=00; beat 1 rdata=0, rresp=10.
- **wlast mismatch:** awlen=1 with wlast on the first beat → both beats written, bresp=10.
- **Reset mid-burst:** rst_n=0 for one cycle during beat 2 of a 4-beat write and a read → all outputs return to their reset values, and beats 3–4 are not written.
